// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and constants for the SEQ-core ALU sharing controller.
// Holds op-codes, FSM state encoding and condition-code reset values.
package alu_ctrl_pkg;

  localparam int ALU_WIDTH = 64;
  localparam int ALU_OPW   = 4;

  localparam logic [ALU_OPW-1:0] ALU_ADD = 4'h0;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 4'h1;
  localparam logic [ALU_OPW-1:0] ALU_AND = 4'h2;
  localparam logic [ALU_OPW-1:0] ALU_XOR = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Last grant resets to requester 1 so the execute stage wins the first tie.
  localparam logic LAST_GRANT_RESET = 1'b1;

  function automatic logic op_is_legal(input logic [ALU_OPW-1:0] op);
    return (op <= ALU_XOR);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response/condition-code bundle between the two ALU requesters,
// the result consumer and the sharing controller.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int OPW   = 4
);

  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_setcc;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_setcc;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;

  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;
  logic             busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_setcc,
    output req1_valid, req1_op, req1_a, req1_b, req1_setcc,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_err,
    input  cc_zf, cc_sf, cc_of, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_setcc,
    input  req1_valid, req1_op, req1_a, req1_b, req1_setcc,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_err,
    output cc_zf, cc_sf, cc_of, busy
  );

endinterface

// File: rtl/alu_share_ctrl_addsub.sv
// Plain modular adder and subtractor used by the shared ALU datapath.
module add64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

module sub64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);

  assign diff = a - b;

endmodule

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone valid requester always wins, and on a
// tie the requester that was not granted last time wins.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1,
  output logic grant_id
);

  always_comb begin
    grant0   = valid0 & (~valid1 | last_grant);
    grant1   = valid1 & (~valid0 | ~last_grant);
    grant_id = grant1;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one shared ALU, runs each op through
// IDLE -> EXEC -> RESP and owns the architectural condition codes.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OPW   = 4
) (
  input logic             clk,
  input logic             rst,
  alu_share_ctrl_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  state_t           state_q;
  state_t           state_d;
  logic             last_grant_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             setcc_q;
  logic             id_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  cc_t              cc_q;

  logic             grant0;
  logic             grant1;
  logic             grant_id;
  logic             in_idle;
  logic             handshake;

  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic             alu_of;

  rr_arb2 u_arb (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant_q),
    .grant0     (grant0),
    .grant1     (grant1),
    .grant_id   (grant_id)
  );

  add64 #(.WIDTH(WIDTH)) u_add (
    .a   (a_q),
    .b   (b_q),
    .sum (add_sum)
  );

  sub64 #(.WIDTH(WIDTH)) u_sub (
    .a    (a_q),
    .b    (b_q),
    .diff (sub_diff)
  );

  // Readys are masked while reset is held so nothing is offered mid-reset.
  assign in_idle   = (state_q == ST_IDLE) & ~rst;
  assign handshake = in_idle & (grant0 | grant1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (handshake)     state_d = ST_EXEC;
      ST_EXEC:                    state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = in_idle & grant0;
    bus.req1_ready = in_idle & grant1;
    bus.rsp_valid  = (state_q == ST_RESP);
    bus.busy       = (state_q != ST_IDLE);
    bus.rsp_id     = id_q;
    bus.rsp_result = result_q;
    bus.rsp_err    = err_q;
    bus.cc_zf      = cc_q.zf;
    bus.cc_sf      = cc_q.sf;
    bus.cc_of      = cc_q.of;
  end

  // Operands are captured only on the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      setcc_q      <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= LAST_GRANT_RESET;
    end else if (handshake) begin
      op_q         <= grant_id ? bus.req1_op    : bus.req0_op;
      a_q          <= grant_id ? bus.req1_a     : bus.req0_a;
      b_q          <= grant_id ? bus.req1_b     : bus.req0_b;
      setcc_q      <= grant_id ? bus.req1_setcc : bus.req0_setcc;
      id_q         <= grant_id;
      last_grant_q <= grant_id;
    end
  end

  // Overflow comes from operand/result sign bits, not from any carry-out.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    alu_of  = 1'b0;
    case (op_q)
      ALU_ADD: begin
        alu_res = add_sum;
        alu_of  = (a_q[MSB] == b_q[MSB]) & (add_sum[MSB] != a_q[MSB]);
      end
      ALU_SUB: begin
        alu_res = sub_diff;
        alu_of  = (a_q[MSB] != b_q[MSB]) & (sub_diff[MSB] != a_q[MSB]);
      end
      ALU_AND: alu_res = a_q & b_q;
      ALU_XOR: alu_res = a_q ^ b_q;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      err_q    <= 1'b0;
      cc_q     <= CC_RESET;
    end else if (state_q == ST_EXEC) begin
      result_q <= alu_res;
      err_q    <= alu_err;
      if (setcc_q && op_is_legal(op_q)) begin
        cc_q <= '{zf: (alu_res == '0), sf: alu_res[MSB], of: alu_of};
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed and random ops compared
// against an arithmetic reference of the ALU, arbitration and flag rules.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  bit   mzf, msf, mof, mlast;

  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(64), .OPW(4)) bus ();

  alu_share_ctrl #(.WIDTH(64), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit v0, input bit v1,
                               input logic [3:0] op0, input logic [3:0] op1,
                               input logic [63:0] a0, input logic [63:0] b0,
                               input logic [63:0] a1, input logic [63:0] b1,
                               input bit s0, input bit s1);
    bus.req0_valid = v0;  bus.req0_op = op0;  bus.req0_a = a0;
    bus.req0_b = b0;      bus.req0_setcc = s0;
    bus.req1_valid = v1;  bus.req1_op = op1;  bus.req1_a = a1;
    bus.req1_b = b1;      bus.req1_setcc = s1;
  endtask

  // Reference ALU: signed overflow taken from a 65-bit sign-extended result.
  function automatic void refAlu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] res, output bit err, output bit of);
    logic signed [64:0] wide;
    res = '0; err = 1'b0; of = 1'b0; wide = '0;
    case (op)
      4'd0: begin
        wide = $signed({a[63], a}) + $signed({b[63], b});
        res  = wide[63:0];
        of   = wide[64] ^ wide[63];
      end
      4'd1: begin
        wide = $signed({a[63], a}) - $signed({b[63], b});
        res  = wide[63:0];
        of   = wide[64] ^ wide[63];
      end
      4'd2:    res = a & b;
      4'd3:    res = a ^ b;
      default: err = 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 4))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [63:0] ccWord();
    return {61'd0, bus.cc_zf, bus.cc_sf, bus.cc_of};
  endfunction

  function automatic logic [63:0] modelCc();
    return {61'd0, mzf, msf, mof};
  endfunction

  task automatic resetModel();
    mzf = 1'b1; msf = 1'b0; mof = 1'b0; mlast = 1'b1;
  endtask

  task automatic updateModel(input bit r, input logic [3:0] op, input logic [63:0] a,
                             input logic [63:0] b, input bit setcc,
                             output logic [63:0] eres, output bit eerr);
    bit eof;
    refAlu(op, a, b, eres, eerr, eof);
    if (setcc && !eerr) begin
      mzf = (eres == 64'd0);
      msf = eres[63];
      mof = eof;
    end
    mlast = r;
  endtask

  // One op from requester r (optionally contended), response held for 'hold' cycles.
  task automatic doOp(input bit r, input bit both, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b, input bit setcc, input int hold);
    logic [3:0]  jop = 4'($urandom_range(0, 3));
    logic [63:0] ja  = {$urandom, $urandom};
    logic [63:0] jb  = {$urandom, $urandom};
    logic [63:0] eres;
    bit          eerr;
    if (r == 1'b0) applyStimulus(1'b1, both, op, jop, a, b, ja, jb, setcc, 1'b1);
    else           applyStimulus(both, 1'b1, jop, op, ja, jb, a, b, 1'b1, setcc);
    bus.rsp_ready = (hold == 0);
    #1;
    checkOutput("ready_win",  {63'd0, r ? bus.req1_ready : bus.req0_ready}, 64'd1);
    checkOutput("ready_lose", {63'd0, r ? bus.req0_ready : bus.req1_ready}, 64'd0);
    @(posedge clk); @(negedge clk);
    applyStimulus(1'b1, 1'b1, jop, jop, ja, jb, jb, ja, 1'b1, 1'b1);
    updateModel(r, op, a, b, setcc, eres, eerr);
    #1;
    checkOutput("exec_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    checkOutput("exec_readys", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
    checkOutput("exec_busy", {63'd0, bus.busy}, 64'd1);
    @(posedge clk); @(negedge clk); #1;
    checkOutput("resp_valid",  {63'd0, bus.rsp_valid}, 64'd1);
    checkOutput("resp_id",     {63'd0, bus.rsp_id}, {63'd0, r});
    checkOutput("resp_result", bus.rsp_result, eres);
    checkOutput("resp_err",    {63'd0, bus.rsp_err}, {63'd0, eerr});
    checkOutput("resp_cc",     ccWord(), modelCc());
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk); #1;
      checkOutput("hold_valid",  {63'd0, bus.rsp_valid}, 64'd1);
      checkOutput("hold_result", bus.rsp_result, eres);
      checkOutput("hold_id",     {63'd0, bus.rsp_id}, {63'd0, r});
      checkOutput("hold_err",    {63'd0, bus.rsp_err}, {63'd0, eerr});
      checkOutput("hold_readys", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
      checkOutput("hold_busy",   {63'd0, bus.busy}, 64'd1);
      checkOutput("hold_cc",     ccWord(), modelCc());
    end
    bus.rsp_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, '0, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk); #1;
    checkOutput("idle_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    checkOutput("idle_busy",      {63'd0, bus.busy}, 64'd0);
  endtask

  // Both requesters stay valid; grants must alternate starting with requester 0.
  task automatic fairRun(input int nops);
    logic [3:0]  op0 = 4'($urandom_range(0, 3)), op1 = 4'($urandom_range(0, 3));
    logic [63:0] a0 = randOperand(), b0 = randOperand();
    logic [63:0] a1 = randOperand(), b1 = randOperand();
    bit          s0 = 1'($urandom_range(0, 1)), s1 = 1'($urandom_range(0, 1));
    logic [63:0] eres;
    bit          eerr;
    bit          w;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < nops; k++) begin
      w = (k % 2 == 1);
      applyStimulus(1'b1, 1'b1, op0, op1, a0, b0, a1, b1, s0, s1);
      #1;
      checkOutput("fair_ready0", {63'd0, bus.req0_ready}, {63'd0, !w});
      checkOutput("fair_ready1", {63'd0, bus.req1_ready}, {63'd0, w});
      @(posedge clk); @(negedge clk);
      if (w) updateModel(w, op1, a1, b1, s1, eres, eerr);
      else   updateModel(w, op0, a0, b0, s0, eres, eerr);
      #1;
      checkOutput("fair_exec_readys", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
      @(posedge clk); @(negedge clk); #1;
      checkOutput("fair_valid",  {63'd0, bus.rsp_valid}, 64'd1);
      checkOutput("fair_id",     {63'd0, bus.rsp_id}, {63'd0, w});
      checkOutput("fair_result", bus.rsp_result, eres);
      checkOutput("fair_cc",     ccWord(), modelCc());
      if (w) begin
        op1 = 4'($urandom_range(0, 3)); a1 = randOperand(); b1 = randOperand();
        s1 = 1'($urandom_range(0, 1));
      end else begin
        op0 = 4'($urandom_range(0, 3)); a0 = randOperand(); b0 = randOperand();
        s0 = 1'($urandom_range(0, 1));
      end
      @(posedge clk); @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, '0, '0, '0, '0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    bit          r;
    bit          both;
    logic [3:0]  op;

    $display("[TB] start");
    resetModel();
    bus.rsp_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 64'd1, 64'd2, '0, '0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    checkOutput("rst_readys",    {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
    checkOutput("rst_rsp_id",    {63'd0, bus.rsp_id}, 64'd0);
    checkOutput("rst_result",    bus.rsp_result, 64'd0);
    checkOutput("rst_err",       {63'd0, bus.rsp_err}, 64'd0);
    checkOutput("rst_cc",        ccWord(), 64'b100);
    checkOutput("rst_busy",      {63'd0, bus.busy}, 64'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, '0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;

    doOp(1'b0, 1'b0, 4'h0, 64'd5, 64'd7, 1'b1, 0);
    doOp(1'b1, 1'b0, 4'h1, 64'd3, 64'd3, 1'b1, 0);
    doOp(1'b1, 1'b0, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 0);

    fairRun(8);

    doOp(1'b0, 1'b0, 4'h3, 64'hFF, 64'h0F, 1'b0, 0);
    doOp(1'b1, 1'b0, 4'h6, 64'h1234, 64'h5678, 1'b1, 5);

    for (int i = 0; i < 12; i++) begin
      both = 1'($urandom_range(0, 1));
      r    = both ? !mlast : 1'($urandom_range(0, 1));
      op   = 4'($urandom_range(0, 5));
      doOp(r, both, op, randOperand(), randOperand(), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 2)));
    end

    doOp(1'b0, 1'b0, 4'h1, 64'd0, 64'd1, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 64'd5, 64'd6, '0, '0, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk); #1;
    checkOutput("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    resetModel();
    #1;
    checkOutput("midrst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    checkOutput("midrst_busy",      {63'd0, bus.busy}, 64'd0);
    checkOutput("midrst_readys",    {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
    checkOutput("midrst_cc",        ccWord(), modelCc());
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, '0, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk); #1;
      checkOutput("postrst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      checkOutput("postrst_busy",      {63'd0, bus.busy}, 64'd0);
    end
    doOp(1'b0, 1'b1, 4'h3, 64'hA5A5, 64'h5A5A, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencing and arbitration controller for the single shared 64-bit ALU datapath (adder, subtractor, AND, XOR) in the SEQ core.
- Two requesters share the ALU with round-robin arbitration:
  - req0: execute stage.
  - req1: address/aux path.
- Runs one operation at a time through a three-state sequence.
- Owns the architectural condition codes (ZF, SF, OF) and updates them on request.

Parameters:
- WIDTH, 64, operand/result width in bits.
- OPW, 4, op-code width (Y86 ifun encoding).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle (handshake = valid & ready).
- req0_op  input  OPW  0=add, 1=sub, 2=and, 3=xor.
- req0_a  input  WIDTH  operand A.
- req0_b  input  WIDTH  operand B.
- req0_setcc  input  1  update CC with this result.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_setcc: same as req0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_id  output  1  requester index that owns the result.
- rsp_result  output  WIDTH  ALU result.
- rsp_err  output  1  op code was illegal.
- cc_zf  output  1  zero flag.
- cc_sf  output  1  sign flag.
- cc_of  output  1  signed-overflow flag.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values (async, immediate):
  - state=IDLE; req0_ready=req1_ready=0; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_err=0.
  - cc_zf=1, cc_sf=0, cc_of=0; last_grant=1, so req0 wins first.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - The arbiter combinationally asserts reqN_ready for exactly one valid requester.
  - If only one is valid, it wins.
  - If both are valid, the winner is the one != last_grant.
  - No ready is asserted when neither is valid.
  - On handshake: latch op, a, b, setcc and id; set last_grant=id; go to EXEC.
- EXEC:
  - ALU evaluates the latched operands.
    - add: a+b mod 2^WIDTH.
    - sub: a-b mod 2^WIDTH.
    - and: a&b.
    - xor: a^b.
    - op>3: result 0, err=1.
  - Register result and err; go to RESP.
  - If setcc=1 and op is legal, update CC in the same edge:
    - ZF = (result==0).
    - SF = result[WIDTH-1].
    - OF (add) = (a[MSB]==b[MSB]) & (res[MSB]!=a[MSB]).
    - OF (sub) = (a[MSB]!=b[MSB]) & (res[MSB]!=a[MSB]).
    - OF (and/xor) = 0.
  - OF is computed from sign bits in this block, not taken from the subtractor's carry-out.
  - Illegal op or setcc=0: CC is unchanged.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable while rsp_valid & !rsp_ready.
  - On rsp_ready: rsp_valid drops next cycle; go to IDLE.
- Latency and throughput:
  - Handshake in cycle N -> rsp_valid in cycle N+2 at earliest.
  - One op per 3 cycles minimum.
  - Both readys are 0 outside IDLE.
- Requester inputs are sampled only at handshake; later changes to a, b or op do not affect the in-flight op.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...
- Reset mid-operation: the in-flight op is discarded with no response, and CC returns to reset values.

Decomposition:
- Package alu_ctrl_pkg holds:
  - op constants ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_AND=4'h2, ALU_XOR=4'h3;
  - state encoding ST_IDLE, ST_EXEC, ST_RESP;
  - CC reset constants.
- Sub-module rr_arb2:
  - combinational two-way round-robin grant from the valids and last_grant.
- The datapath instantiates the existing 64-bit add and sub modules for ops 0/1.

Test Plan:
- Reset then req0 add a=5, b=7, setcc=1 -> rsp_valid 2 cycles after handshake; result=12, rsp_id=0; ZF=0, SF=0, OF=0.
- req1 sub a=3, b=3, setcc=1 -> result=0, ZF=1, rsp_id=1. Then add 0x7FFF_FFFF_FFFF_FFFF+1, setcc=1 -> result 0x8000_0000_0000_0000, SF=1, OF=1.
- Both requesters valid with 4 ops each, rsp_ready tied 1 -> grant order 0,1,0,1,0,1,0,1; each response carries the correct id.
- xor 0xFF^0x0F with setcc=0 -> result 0xF0; CC unchanged from prior values.
- op=4'h6 -> rsp_err=1, result=0, CC unchanged; hold rsp_ready=0 for 5 cycles -> outputs stable, both readys 0, busy=1.
- Assert rst during EXEC -> next cycle state IDLE, rsp_valid=0, CC=(1,0,0); no stale response after release.
